// File: rtl/ram_responder.sv
// ram_responder: CPU-side RAM with a byte-stream loader that holds the CPU in reset while filling.
// Define RAM_PARITY_EN to add per-byte even parity and a sticky parity_err output.
module ram_responder #(
    parameter int ADDR_W        = 8,
    parameter bit LOAD_ON_RESET = 1'b1
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic [ADDR_W-1:0] addr_bus,
    input  logic              c_ri,
    input  logic              c_ro,
    inout  wire  [7:0]        bus,
    input  logic              load_start,
    input  logic              load_valid,
    input  logic [7:0]        load_data,
    input  logic              load_last,
    output logic              load_ready,
    output logic              cpu_hold,
    output logic [ADDR_W-1:0] load_count,
    output logic              bus_conflict
`ifdef RAM_PARITY_EN
    ,
    output logic              parity_err
`endif
);
    localparam int DEPTH = 2 ** ADDR_W;

    typedef enum logic {LOAD, RUN} state_t;

    state_t            state, state_next;
    logic [7:0]        mem [DEPTH];
    logic              accept, rd_en, wr_en, conflict;
    logic [ADDR_W-1:0] count_next, wr_addr;
    logic [7:0]        wr_data;

    always_comb begin
        load_ready = state == LOAD;
        cpu_hold   = state == LOAD;
        accept     = load_ready & load_valid;
        rd_en      = state == RUN & c_ro & ~c_ri;
        wr_en      = state == RUN & c_ri & ~c_ro;
        conflict   = state == RUN & c_ri & c_ro;
        wr_addr    = accept ? load_count : addr_bus;
        wr_data    = accept ? load_data : bus;
        state_next = state;
        count_next = load_count;
        if (accept) begin
            count_next = load_count + 1'b1;
            // a full-depth load ends on its own and leaves the counter wrapped to 0
            if (load_last || &load_count)
                state_next = RUN;
        end else if (state == RUN && load_start) begin
            state_next = LOAD;
            count_next = '0;
        end
    end

    assign bus = rd_en ? mem[addr_bus] : 'z;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state        <= LOAD_ON_RESET ? LOAD : RUN;
            load_count   <= '0;
            bus_conflict <= 1'b0;
        end else begin
            state        <= state_next;
            load_count   <= count_next;
            bus_conflict <= bus_conflict | conflict;
        end
    end

    always_ff @(posedge clk)
        if (accept || wr_en)
            mem[wr_addr] <= wr_data;

`ifdef RAM_PARITY_EN
    logic par [DEPTH];

    always_ff @(posedge clk)
        if (accept || wr_en)
            par[wr_addr] <= ^wr_data;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n)
            parity_err <= 1'b0;
        else if (rd_en && par[addr_bus] != ^mem[addr_bus])
            parity_err <= 1'b1;
    end
`endif

endmodule
